// File: rtl/regfile_sb_param.sv
// Register file with two read ports and one write port. It also keeps a busy
// scoreboard with one busy bit per register: decode reserves a register and
// writeback releases it.
module regfile_sb_param #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned REG_READ = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              flush,
  output logic [DATA_W-1:0] rs,
  output logic [DATA_W-1:0] rt,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [CNT_W-1:0]  busy_cnt_q;
  logic [CNT_W-1:0]  busy_cnt_d;

  logic              wr_ok;
  logic              rsv_ok;
  logic [DATA_W-1:0] rs_sel;
  logic [DATA_W-1:0] rt_sel;
  logic              rs_busy_sel;
  logic              rt_busy_sel;

  // Writes and reserves aimed at a hardwired register 0 are dropped here.
  always_comb begin
    wr_ok  = en;
    rsv_ok = rsv_en;
    if ((ZERO_REG != 0) && (wr_addr == '0)) begin
      wr_ok = 1'b0;
    end
    if ((ZERO_REG != 0) && (rsv_addr == '0)) begin
      rsv_ok = 1'b0;
    end
  end

  // Next register contents.
  always_comb begin
    regs_d = regs_q;
    if (wr_ok) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // Next busy bits (flush > reserve > writeback) and their popcount.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_ok) begin
        busy_d[wr_addr] = 1'b0;
      end
      if (rsv_ok) begin
        busy_d[rsv_addr] = 1'b1;
      end
    end
    busy_cnt_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      busy_cnt_d = busy_cnt_d + CNT_W'(busy_d[i]);
    end
  end

  // Read-port selection. With bypass it is write-first; without bypass it is read-first.
  always_comb begin
    rs_sel = regs_q[rs_addr];
    rt_sel = regs_q[rt_addr];
    if ((BYPASS != 0) && wr_ok && (wr_addr == rs_addr)) begin
      rs_sel = wr_data;
    end
    if ((BYPASS != 0) && wr_ok && (wr_addr == rt_addr)) begin
      rt_sel = wr_data;
    end
    if ((ZERO_REG != 0) && (rs_addr == '0)) begin
      rs_sel = '0;
    end
    if ((ZERO_REG != 0) && (rt_addr == '0)) begin
      rt_sel = '0;
    end
    if (BYPASS != 0) begin
      rs_busy_sel = busy_d[rs_addr];
      rt_busy_sel = busy_d[rt_addr];
    end else begin
      rs_busy_sel = busy_q[rs_addr];
      rt_busy_sel = busy_q[rt_addr];
    end
  end

  // Register array, busy bits and busy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  generate
    if (REG_READ != 0) begin : g_reg_read
      logic [DATA_W-1:0] rs_q;
      logic [DATA_W-1:0] rs_d;
      logic [DATA_W-1:0] rt_q;
      logic [DATA_W-1:0] rt_d;
      logic              rs_busy_q;
      logic              rs_busy_d;
      logic              rt_busy_q;
      logic              rt_busy_d;

      // Registered read ports capture the selected values.
      always_comb begin
        rs_d      = rs_sel;
        rt_d      = rt_sel;
        rs_busy_d = rs_busy_sel;
        rt_busy_d = rt_busy_sel;
      end

      // Read-port registers. Read data appears one cycle after the address.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rs_q      <= '0;
          rt_q      <= '0;
          rs_busy_q <= 1'b0;
          rt_busy_q <= 1'b0;
        end else begin
          rs_q      <= rs_d;
          rt_q      <= rt_d;
          rs_busy_q <= rs_busy_d;
          rt_busy_q <= rt_busy_d;
        end
      end

      assign rs      = rs_q;
      assign rt      = rt_q;
      assign rs_busy = rs_busy_q;
      assign rt_busy = rt_busy_q;
    end else begin : g_comb_read
      assign rs      = rs_sel;
      assign rt      = rt_sel;
      assign rs_busy = rs_busy_sel;
      assign rt_busy = rt_busy_sel;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb_param.sv
// Bench for regfile_sb_param. It drives two instances with the same inputs:
// dut uses the defaults (combinational read, bypass).
// dut_rr uses registered read ports and read-first behaviour (BYPASS=0).
module tb_regfile_sb_param;

  logic        clk;
  logic        rst;
  logic        en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  rs_addr;
  logic [2:0]  rt_addr;
  logic        rsv_en;
  logic [2:0]  rsv_addr;
  logic        flush;

  logic [15:0] rs;
  logic [15:0] rt;
  logic        rs_busy;
  logic        rt_busy;
  logic [3:0]  busy_cnt;

  logic [15:0] rr_rs;
  logic [15:0] rr_rt;
  logic        rr_rs_busy;
  logic        rr_rt_busy;
  logic [3:0]  rr_busy_cnt;

  int n_total;
  int n_pass;

  // Scoreboard of values expected after the next clock edge.
  logic [15:0] exp_q[$];

  regfile_sb_param dut (
    .clk(clk), .rst(rst), .en(en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .flush(flush), .rs(rs), .rt(rt), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .busy_cnt(busy_cnt)
  );

  regfile_sb_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0), .REG_READ(1)) dut_rr (
    .clk(clk), .rst(rst), .en(en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .flush(flush), .rs(rr_rs), .rt(rr_rt), .rs_busy(rr_rs_busy), .rt_busy(rr_rt_busy),
    .busy_cnt(rr_busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    en       = 1'b0;
    wr_addr  = 3'd0;
    wr_data  = 16'h0000;
    rsv_en   = 1'b0;
    rsv_addr = 3'd0;
    flush    = 1'b0;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] e;
    idle();
    en = 1'b1; wr_addr = 3'd1; wr_data = 16'hAAAA;
    rsv_en = 1'b1; rsv_addr = 3'd1;
    rs_addr = 3'd1; rt_addr = 3'd1;
    tick();
    idle();
    exp_q.push_back(16'hAAAA);
    tick();
    e = exp_q.pop_front();
    n_total++;
    if (rr_rs !== e) $display("FAIL pre_reset_rr_rs actual=%h required=%h", rr_rs, e);
    else n_pass++;
    n_total++;
    if (busy_cnt !== 4'd1) $display("FAIL pre_reset_busy_cnt actual=%0d required=1", busy_cnt);
    else n_pass++;
    n_total++;
    if (rs_busy !== 1'b1) $display("FAIL pre_reset_rs_busy actual=%b required=1", rs_busy);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if (busy_cnt !== 4'd0) $display("FAIL async_reset_busy_cnt actual=%0d required=0", busy_cnt);
    else n_pass++;
    n_total++;
    if (rr_rs !== 16'h0 || rr_rt !== 16'h0 || rr_rs_busy !== 1'b0 || rr_busy_cnt !== 4'd0)
      $display("FAIL async_reset_rr actual=%h/%h/%b/%0d required=0/0/0/0",
               rr_rs, rr_rt, rr_rs_busy, rr_busy_cnt);
    else n_pass++;
    n_total++;
    if (rs !== 16'h0 || rs_busy !== 1'b0) $display("FAIL async_reset_rs actual=%h/%b required=0/0", rs, rs_busy);
    else n_pass++;
    for (int a = 0; a < 8; a++) begin
      @(negedge clk);
      rs_addr = 3'(a);
      rt_addr = 3'(7 - a);
      #1;
      n_total++;
      if (rs !== 16'h0 || rt !== 16'h0)
        $display("FAIL reset_read_addr%0d actual=%h/%h required=0/0", a, rs, rt);
      else n_pass++;
    end
    #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    logic [15:0] e;
    idle();
    en = 1'b1; wr_addr = 3'd5; wr_data = 16'h1234;
    rs_addr = 3'd0; rt_addr = 3'd0;
    tick();
    idle();
    rs_addr = 3'd5; rt_addr = 3'd5;
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'h1234);
    #3;
    n_total++;
    if (rs !== 16'h1234 || rt !== 16'h1234) $display("FAIL write_read_comb actual=%h/%h required=1234/1234", rs, rt);
    else n_pass++;
    n_total++;
    if (rr_rs !== 16'h0) $display("FAIL write_read_latency actual=%h required=0000", rr_rs);
    else n_pass++;
    tick();
    e = exp_q.pop_front();
    n_total++;
    if (rr_rs !== e) $display("FAIL write_read_rr_rs actual=%h required=%h", rr_rs, e);
    else n_pass++;
    e = exp_q.pop_front();
    n_total++;
    if (rr_rt !== e) $display("FAIL write_read_rr_rt actual=%h required=%h", rr_rt, e);
    else n_pass++;
  endtask

  task automatic test_bypass();
    logic [15:0] e;
    idle();
    en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
    rs_addr = 3'd3; rt_addr = 3'd3;
    exp_q.push_back(16'h0000);
    #3;
    n_total++;
    if (rs !== 16'hBEEF || rt !== 16'hBEEF) $display("FAIL bypass_comb actual=%h/%h required=beef/beef", rs, rt);
    else n_pass++;
    tick();
    e = exp_q.pop_front();
    n_total++;
    if (rr_rs !== e) $display("FAIL bypass_read_first actual=%h required=%h", rr_rs, e);
    else n_pass++;
    idle();
    exp_q.push_back(16'hBEEF);
    tick();
    e = exp_q.pop_front();
    n_total++;
    if (rr_rs !== e) $display("FAIL bypass_after_write actual=%h required=%h", rr_rs, e);
    else n_pass++;
  endtask

  task automatic test_zero_reg();
    idle();
    en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
    rsv_en = 1'b1; rsv_addr = 3'd0;
    rs_addr = 3'd0; rt_addr = 3'd0;
    #3;
    n_total++;
    if (rs !== 16'h0 || rs_busy !== 1'b0) $display("FAIL zero_bypass actual=%h/%b required=0/0", rs, rs_busy);
    else n_pass++;
    tick();
    idle();
    #3;
    n_total++;
    if (rs !== 16'h0 || rt !== 16'h0 || rs_busy !== 1'b0 || busy_cnt !== 4'd0)
      $display("FAIL zero_reg actual=%h/%h/%b/%0d required=0/0/0/0", rs, rt, rs_busy, busy_cnt);
    else n_pass++;
    n_total++;
    if (rr_rs !== 16'h0 || rr_rs_busy !== 1'b0 || rr_busy_cnt !== 4'd0)
      $display("FAIL zero_reg_rr actual=%h/%b/%0d required=0/0/0", rr_rs, rr_rs_busy, rr_busy_cnt);
    else n_pass++;
    tick();
  endtask

  task automatic test_scoreboard();
    logic [15:0] e;
    idle();
    rs_addr = 3'd2; rt_addr = 3'd4;
    rsv_en = 1'b1; rsv_addr = 3'd2;
    exp_q.push_back(16'd1);
    #3;
    n_total++;
    if (rs_busy !== 1'b1 || rt_busy !== 1'b0) $display("FAIL sb_rsv2_busy actual=%b/%b required=1/0", rs_busy, rt_busy);
    else n_pass++;
    tick();
    e = exp_q.pop_front();
    n_total++;
    if (busy_cnt !== 4'(e)) $display("FAIL sb_rsv2_cnt actual=%0d required=%0d", busy_cnt, e);
    else n_pass++;
    rsv_addr = 3'd4;
    exp_q.push_back(16'd2);
    tick();
    e = exp_q.pop_front();
    n_total++;
    if (busy_cnt !== 4'(e)) $display("FAIL sb_rsv4_cnt actual=%0d required=%0d", busy_cnt, e);
    else n_pass++;
    en = 1'b1; wr_addr = 3'd2; wr_data = 16'h0022;
    rsv_en = 1'b1; rsv_addr = 3'd2;
    exp_q.push_back(16'd2);
    #3;
    n_total++;
    if (rs_busy !== 1'b1 || rs !== 16'h0022) $display("FAIL sb_wb_rsv_same actual=%b/%h required=1/0022", rs_busy, rs);
    else n_pass++;
    tick();
    e = exp_q.pop_front();
    n_total++;
    if (busy_cnt !== 4'(e)) $display("FAIL sb_wb_rsv_cnt actual=%0d required=%0d", busy_cnt, e);
    else n_pass++;
    rsv_en = 1'b0;
    en = 1'b1; wr_addr = 3'd4; wr_data = 16'h0044;
    exp_q.push_back(16'd1);
    exp_q.push_back(16'd1);
    #3;
    n_total++;
    if (rt_busy !== 1'b0 || rs_busy !== 1'b1) $display("FAIL sb_wb4_busy actual=%b/%b required=0/1", rt_busy, rs_busy);
    else n_pass++;
    tick();
    e = exp_q.pop_front();
    n_total++;
    if (busy_cnt !== 4'(e)) $display("FAIL sb_wb4_cnt actual=%0d required=%0d", busy_cnt, e);
    else n_pass++;
    e = exp_q.pop_front();
    n_total++;
    if (rr_rt_busy !== e[0]) $display("FAIL sb_wb4_rr_busy actual=%b required=%b", rr_rt_busy, e[0]);
    else n_pass++;
    en = 1'b0;
    flush = 1'b1; rsv_en = 1'b1; rsv_addr = 3'd6; rs_addr = 3'd6;
    exp_q.push_back(16'd0);
    exp_q.push_back(16'd0);
    #3;
    n_total++;
    if (rs_busy !== 1'b0) $display("FAIL sb_flush_rs_busy actual=%b required=0", rs_busy);
    else n_pass++;
    tick();
    e = exp_q.pop_front();
    n_total++;
    if (busy_cnt !== 4'(e)) $display("FAIL sb_flush_cnt actual=%0d required=%0d", busy_cnt, e);
    else n_pass++;
    e = exp_q.pop_front();
    n_total++;
    if (rr_rt_busy !== e[0]) $display("FAIL sb_flush_rr_busy actual=%b required=%b", rr_rt_busy, e[0]);
    else n_pass++;
    idle();
    #3;
    n_total++;
    if (rs_busy !== 1'b0 || rt_busy !== 1'b0) $display("FAIL sb_after_flush actual=%b/%b required=0/0", rs_busy, rt_busy);
    else n_pass++;
    tick();
  endtask

  task automatic test_saturate();
    logic [15:0] e;
    idle();
    rs_addr = 3'd7; rt_addr = 3'd1;
    for (int r = 1; r < 8; r++) begin
      rsv_en = 1'b1; rsv_addr = 3'(r);
      exp_q.push_back(16'(r));
      tick();
      e = exp_q.pop_front();
      n_total++;
      if (busy_cnt !== 4'(e) || rr_busy_cnt !== 4'(e))
        $display("FAIL sat_rsv%0d actual=%0d/%0d required=%0d", r, busy_cnt, rr_busy_cnt, e);
      else n_pass++;
    end
    rsv_addr = 3'd7;
    exp_q.push_back(16'd7);
    tick();
    e = exp_q.pop_front();
    n_total++;
    if (busy_cnt !== 4'(e)) $display("FAIL sat_rersv7 actual=%0d required=%0d", busy_cnt, e);
    else n_pass++;
    n_total++;
    if (rs_busy !== 1'b1 || rt_busy !== 1'b1) $display("FAIL sat_busy_bits actual=%b/%b required=1/1", rs_busy, rt_busy);
    else n_pass++;
    rsv_en = 1'b0;
    flush = 1'b1;
    exp_q.push_back(16'd0);
    tick();
    e = exp_q.pop_front();
    n_total++;
    if (busy_cnt !== 4'(e)) $display("FAIL sat_flush actual=%0d required=%0d", busy_cnt, e);
    else n_pass++;
    idle();
    tick();
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst     = 1'b1;
    rs_addr = 3'd0;
    rt_addr = 3'd0;
    idle();
    #12;
    rst = 1'b0;
    tick();
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Time bound on the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
